// File: rtl/mux2x1_arbiter.sv
// mux2x1_arbiter: round-robin two-requester arbiter with registered grants and a shared data mux.
// Define ARB_TIMEOUT_EN to bound each grant to MAXHOLD cycles while the other side is waiting.
module mux2x1_arbiter #(
    parameter int WIDTH   = 1,
    parameter int MAXHOLD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             R0,
    input  logic             R1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             G0,
    output logic             G1,
    output logic             S,
    output logic [WIDTH-1:0] Y,
    output logic             VALID
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   timeout;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;

    always_comb begin
        timeout    = hold_cnt_q == 8'(MAXHOLD - 1);
        hold_cnt_d = (state_d == IDLE || state_d != state_q) ? 8'd0 :
                     timeout ? hold_cnt_q : hold_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) hold_cnt_q <= 8'd0;
        else     hold_cnt_q <= hold_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // a timed-out holder only yields when the other side is actually asking
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (R0 && R1) ? (last_q ? GNT0 : GNT1) :
                               R0 ? GNT0 : R1 ? GNT1 : IDLE;
            GNT0:    state_d = (R0 && !(timeout && R1)) ? GNT0 : R1 ? GNT1 : IDLE;
            GNT1:    state_d = (R1 && !(timeout && R0)) ? GNT1 : R0 ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        last_d = (state_d == GNT0) ? 1'b0 : (state_d == GNT1) ? 1'b1 : last_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign G0    = state_q == GNT0;
    assign G1    = state_q == GNT1;
    assign S     = G1;
    assign VALID = G0 | G1;
    assign Y     = G0 ? D0 : G1 ? D1 : '0;
endmodule

// File: doc/mux2x1_arbiter.md
MUX2X1_ARBITER -- requirements
Module: mux2x1_arbiter

Interface
REQ-001 Parameter: WIDTH, 1, data width of D0, D1 and Y.
REQ-002 Parameter: MAXHOLD, 4, maximum grant length in cycles when ARB_TIMEOUT_EN is defined (legal range 2..255).
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 R0  input  1  request from requester 0.
REQ-006 R1  input  1  request from requester 1.
REQ-007 D0  input  WIDTH  data from requester 0.
REQ-008 D1  input  WIDTH  data from requester 1.
REQ-009 G0  output  1  registered grant to requester 0.
REQ-010 G1  output  1  registered grant to requester 1.
REQ-011 S  output  1  mux select: 1 in GNT1, 0 otherwise.
REQ-012 Y  output  WIDTH  shared output: D0 in GNT0, D1 in GNT1, all-zero in IDLE.
REQ-013 VALID  output  1  G0 | G1.

Function
REQ-014 FSM states SHALL be IDLE, GNT0 and GNT1; G0=1 only in GNT0, G1=1 only in GNT1; G0 and G1 never both 1.
REQ-015 Grant latency SHALL be one cycle: a request seen at rising edge n with the arbiter free gives the grant after edge n.
REQ-016 IDLE, only R0=1 -> GNT0; only R1=1 -> GNT1; neither -> stay IDLE.
REQ-017 IDLE, R0=R1=1 -> grant the port not named by the internal LAST flag (round-robin).
REQ-018 LAST SHALL be updated to the granted port on every entry into GNT0 or GNT1.
REQ-019 GNTx SHALL hold while Rx=1, except as stated in REQ-026.
REQ-020 GNTx with Rx=0 and the other request=1 -> go directly to the other grant state, with no IDLE cycle between.
REQ-021 GNTx with Rx=0 and the other request=0 -> IDLE.
REQ-022 Y and S SHALL be combinational from the state register and D0/D1; Y follows D changes within the same cycle.
REQ-023 HOLD_CNT (8 bits) SHALL clear on every grant entry and increment each cycle in a grant state, saturating at MAXHOLD-1.

Reset
REQ-024 RST=1 SHALL immediately, without a clock, force IDLE, G0=G1=0, S=0, Y=0, VALID=0, HOLD_CNT=0 and LAST=1, so port 0 wins the first tie.
REQ-025 RST asserted during a grant SHALL drop the grant at once; after RST falls, arbitration restarts from IDLE on the next edge.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined: in GNTx with HOLD_CNT=MAXHOLD-1 and the other request=1, the next edge SHALL switch to the other grant even if Rx=1; if the other request=0 the grant continues and HOLD_CNT stays saturated.
REQ-027 Without ARB_TIMEOUT_EN: the HOLD_CNT logic and REQ-026 are absent, and a grant holds until it is released (no starvation bound).

Verification
REQ-028 RST=1 mid-stream with R0=1 and G0=1 -> G0, S, Y and VALID go to 0 before the next CLK edge; after RST falls with R0=R1=1, G0 is granted one edge later.
REQ-029 From IDLE, R0=R1=1 twice in turn, each held 1 cycle then released -> grants GNT0 then GNT1 (round-robin); Y=D0 then Y=D1 with D0=1, D1=0 (WIDTH=1).
REQ-030 In GNT0, drop R0 on the same edge R1 rises -> GNT1 on the next edge, VALID stays 1 throughout.
REQ-031 ARB_TIMEOUT_EN, MAXHOLD=4, R0 and R1 held 1 -> G0 for exactly 4 cycles, then G1 for 4, alternating.
REQ-032 No ARB_TIMEOUT_EN, R0 and R1 held 1 for 12 cycles -> G0 stays 1 for all 12; release R0 -> G1 on the next edge.
REQ-033 IDLE with D0 and D1 toggling -> Y=0, S=0 and VALID=0 every cycle.
